// File: rtl/proc_isa_pkg.sv
// ISA constants and FSM state type shared by the 4-bit processor front end.
// Opcode 1010 (JZ) is only legal when built with JZ_EN.
package proc_isa_pkg;

  localparam int OPC_W = 4;
  localparam int OPR_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0011;
  localparam logic [OPC_W-1:0] OP_CMP = 4'b0110;
  localparam logic [OPC_W-1:0] OP_JMP = 4'b1001;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'b1010;
  localparam logic [OPC_W-1:0] OP_IN  = 4'b1011;
  localparam logic [OPC_W-1:0] OP_STA = 4'b1101;
  localparam logic [OPC_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPC_W-1:0] OP_LDI = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

endpackage

// File: rtl/isa_decoder.sv
// Combinational opcode classifier: legality and jump kind.
// JZ_EN adds opcode 1010 as a conditional jump.
import proc_isa_pkg::*;

module isa_decoder (
  input  logic [OPC_W-1:0] opc_i,
  output logic             legal_o,
  output logic             is_jump_o,
  output logic             is_cond_jump_o
);

  always_comb begin
    legal_o        = 1'b0;
    is_jump_o      = 1'b0;
    is_cond_jump_o = 1'b0;
    unique case (opc_i)
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_CMP,
      OP_IN,
      OP_STA,
      OP_OUT,
      OP_LDI: legal_o = 1'b1;
      OP_JMP: begin
        legal_o   = 1'b1;
        is_jump_o = 1'b1;
      end
`ifdef JZ_EN
      OP_JZ: begin
        legal_o        = 1'b1;
        is_cond_jump_o = 1'b1;
      end
`endif
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/decode front end: FETCH -> WAIT -> DECODE -> EXEC, HALT on range exit.
// Optional JZ_EN enables the zero-flag conditional jump (see isa_decoder).
import proc_isa_pkg::*;

module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = 28,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] address,
  input  logic [7:0]        prog_data,
  output logic [OPC_W-1:0]  opcode,
  output logic [OPR_W-1:0]  operand,
  output logic              exec_valid,
  input  logic              exec_ready,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              zero_flag,
  output logic              halted,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [OPC_W-1:0]  opc_q;
  logic [OPR_W-1:0]  opr_q;
  logic              valid_q;
  logic              halted_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              legal;
  logic              is_jump;
  logic              is_cjump;
  logic              take_d;
  logic [ADDR_W:0]   seq_d;
  logic [ADDR_W:0]   tgt_d;
  logic              seq_out_d;
  logic              tgt_out_d;

  isa_decoder u_dec (
    .opc_i          (opc_q),
    .legal_o        (legal),
    .is_jump_o      (is_jump),
    .is_cond_jump_o (is_cjump)
  );

  // Next-PC math is one bit wider so PC+1 never wraps past the range check.
  always_comb begin
    take_d    = is_jump | (is_cjump & zero_flag);
    seq_d     = {1'b0, pc_q} + ONE;
    tgt_d     = take_d ? {1'b0, jmp_addr} : seq_d;
    seq_out_d = (seq_d >= LEN);
    tgt_out_d = (tgt_d >= LEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      opc_q     <= '0;
      opr_q     <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          opc_q   <= prog_data[7:4];
          opr_q   <= prog_data[3:0];
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (legal) begin
            valid_q <= 1'b1;
            state_q <= S_EXEC;
          end else begin
            illegal_q <= 1'b1;
            if (seq_out_d) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              pc_q    <= seq_d[ADDR_W-1:0];
              state_q <= S_FETCH;
            end
          end
        end
        S_EXEC: begin
          if (exec_ready) begin
            valid_q <= 1'b0;
            if (cnt_q != '1)
              cnt_q <= cnt_q + 1'b1;
            if (tgt_out_d) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              pc_q    <= tgt_d[ADDR_W-1:0];
              state_q <= S_FETCH;
            end
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign address     = pc_q;
  assign opcode      = opc_q;
  assign operand     = opr_q;
  assign exec_valid  = valid_q;
  assign halted      = halted_q;
  assign illegal_op  = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a registered program memory model.
// Build with JZ_EN defined to exercise the conditional jump.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  address;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [3:0]  operand;
  logic        exec_valid;
  logic        exec_ready = 1'b1;
  logic [7:0]  jmp_addr = 8'd0;
  logic        zero_flag = 1'b0;
  logic        halted;
  logic        illegal_op;
  logic [15:0] instr_count;

  logic [7:0]  mem [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= mem[address];

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .prog_data   (prog_data),
    .opcode      (opcode),
    .operand     (operand),
    .exec_valid  (exec_valid),
    .exec_ready  (exec_ready),
    .jmp_addr    (jmp_addr),
    .zero_flag   (zero_flag),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  task automatic load_ldi();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  // Leaves the bench at the negedge where cycle 1 (FETCH of PC 0) is visible.
  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load_ldi();
    mem[0] = 8'hF1;
    exec_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({address, exec_valid, opcode, operand} !== 17'd0) begin
      errors++;
      $display("FAIL reset_bus got %h/%b/%h/%h want 0/0/0/0",
               address, exec_valid, opcode, operand);
    end
    checks++;
    if ({halted, illegal_op, instr_count} !== 18'd0) begin
      errors++;
      $display("FAIL reset_status got %b/%b/%0d want 0/0/0",
               halted, illegal_op, instr_count);
    end
    rst = 1'b0;
    checks++;
    if (address !== 8'd0) begin
      errors++;
      $display("FAIL first_addr got %0d want 0", address);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exec_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid got %b want 0", exec_valid);
    end
    @(negedge clk);
    checks++;
    if (exec_valid !== 1'b1 || opcode !== 4'hF || operand !== 4'h1) begin
      errors++;
      $display("FAIL first_exec got %b/%h/%h want 1/f/1",
               exec_valid, opcode, operand);
    end
    @(negedge clk);
    checks++;
    if (instr_count !== 16'd1 || exec_valid !== 1'b0 || address !== 8'd1) begin
      errors++;
      $display("FAIL first_retire got %0d/%b/%0d want 1/0/1",
               instr_count, exec_valid, address);
    end
  endtask

  task automatic test_run();
    bit ok;
    load_ldi();
    exec_ready = 1'b1;
    reset_dut();
    ok = 1'b1;
    for (int i = 0; i < 28; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (address !== 8'(i) || exec_valid !== (c == 3) || halted !== 1'b0)
          ok = 1'b0;
        @(negedge clk);
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_seq got ok=%b want ok=1", ok);
    end
    checks++;
    if (halted !== 1'b1 || instr_count !== 16'd28 || address !== 8'd27) begin
      errors++;
      $display("FAIL run_halt got %b/%0d/%0d want 1/28/27",
               halted, instr_count, address);
    end
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (exec_valid !== 1'b0 || halted !== 1'b1 || instr_count !== 16'd28)
        ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL halt_sticky got ok=%b want ok=1", ok);
    end
  endtask

  task automatic test_stall();
    bit ok;
    load_ldi();
    mem[0] = 8'hD2;
    exec_ready = 1'b0;
    reset_dut();
    repeat (3) @(negedge clk);
    ok = 1'b1;
    repeat (5) begin
      if (exec_valid !== 1'b1 || opcode !== 4'hD || operand !== 4'h2 ||
          address !== 8'd0 || instr_count !== 16'd0)
        ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_hold got ok=%b want ok=1", ok);
    end
    exec_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (exec_valid !== 1'b0 || address !== 8'd1 || instr_count !== 16'd1) begin
      errors++;
      $display("FAIL stall_release got %b/%0d/%0d want 0/1/1",
               exec_valid, address, instr_count);
    end
  endtask

  task automatic test_jmp();
    load_ldi();
    mem[25] = 8'h9F;
    exec_ready = 1'b1;
    jmp_addr = 8'd6;
    reset_dut();
    repeat (103) @(negedge clk);
    checks++;
    if (exec_valid !== 1'b1 || opcode !== 4'h9 || address !== 8'd25) begin
      errors++;
      $display("FAIL jmp_exec got %b/%h/%0d want 1/9/25",
               exec_valid, opcode, address);
    end
    @(negedge clk);
    checks++;
    if (address !== 8'd6 || halted !== 1'b0) begin
      errors++;
      $display("FAIL jmp_target got %0d/%b want 6/0", address, halted);
    end
    jmp_addr = 8'd40;
    reset_dut();
    repeat (104) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || address !== 8'd25 || instr_count !== 16'd26 ||
        exec_valid !== 1'b0) begin
      errors++;
      $display("FAIL jmp_range got %b/%0d/%0d/%b want 1/25/26/0",
               halted, address, instr_count, exec_valid);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    load_ldi();
    mem[3] = 8'h40;
    exec_ready = 1'b1;
    reset_dut();
    repeat (11) @(negedge clk);
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pre got %b want 0", illegal_op);
    end
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (exec_valid !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL illegal_novalid got ok=%b want ok=1", ok);
    end
    @(negedge clk);
    checks++;
    if (illegal_op !== 1'b1 || address !== 8'd4 || instr_count !== 16'd3) begin
      errors++;
      $display("FAIL illegal_skip got %b/%0d/%0d want 1/4/3",
               illegal_op, address, instr_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exec_valid !== 1'b1 || illegal_op !== 1'b1 || address !== 8'd4) begin
      errors++;
      $display("FAIL illegal_resume got %b/%b/%0d want 1/1/4",
               exec_valid, illegal_op, address);
    end
  endtask

  task automatic test_rst_mid();
    load_ldi();
    exec_ready = 1'b1;
    reset_dut();
    repeat (43) @(negedge clk);
    exec_ready = 1'b0;
    checks++;
    if (exec_valid !== 1'b1 || address !== 8'd10 || instr_count !== 16'd10) begin
      errors++;
      $display("FAIL pre_rst got %b/%0d/%0d want 1/10/10",
               exec_valid, address, instr_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({address, exec_valid, opcode, operand, instr_count, halted} !== 34'd0) begin
      errors++;
      $display("FAIL async_rst got %0d/%b/%h/%h/%0d/%b want all 0",
               address, exec_valid, opcode, operand, instr_count, halted);
    end
    @(negedge clk);
    rst = 1'b0;
    exec_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (exec_valid !== 1'b1 || address !== 8'd0 || opcode !== 4'hF) begin
      errors++;
      $display("FAIL rst_restart got %b/%0d/%h want 1/0/f",
               exec_valid, address, opcode);
    end
  endtask

  task automatic test_jz();
    load_ldi();
    mem[0] = 8'hA5;
    exec_ready = 1'b1;
    jmp_addr = 8'd5;
    zero_flag = 1'b1;
    reset_dut();
`ifdef JZ_EN
    repeat (3) @(negedge clk);
    checks++;
    if (exec_valid !== 1'b1 || opcode !== 4'hA || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL jz_exec got %b/%h/%b want 1/a/0",
               exec_valid, opcode, illegal_op);
    end
    @(negedge clk);
    checks++;
    if (address !== 8'd5) begin
      errors++;
      $display("FAIL jz_taken got %0d want 5", address);
    end
    zero_flag = 1'b0;
    reset_dut();
    repeat (4) @(negedge clk);
    checks++;
    if (address !== 8'd1) begin
      errors++;
      $display("FAIL jz_not_taken got %0d want 1", address);
    end
`else
    repeat (3) @(negedge clk);
    checks++;
    if (illegal_op !== 1'b1 || address !== 8'd1 || exec_valid !== 1'b0) begin
      errors++;
      $display("FAIL jz_disabled got %b/%0d/%b want 1/1/0",
               illegal_op, address, exec_valid);
    end
`endif
    zero_flag = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_jmp();
    test_illegal();
    test_rst_mid();
    test_jz();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch/decode front end for the 4-bit processor. It is the reader side of program_memory: it drives the program address, absorbs the memory's one-cycle registered read latency, and splits each 8-bit word into opcode[7:4] and operand[3:0]. It presents each instruction to the datapath with a valid/ready handshake and owns the program counter, including JMP.

Parameters:
ADDR_W, 8, program address width.
PROG_LEN, 28, number of valid program words; a PC at or beyond this value halts the unit (1..2**ADDR_W).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
address  output  ADDR_W  program address to program_memory; always equals the internal PC.
prog_data  input  8  registered read data from program_memory.
opcode  output  4  decoded opcode (prog_data[7:4]).
operand  output  4  immediate value or RAM address (prog_data[3:0]).
exec_valid  output  1  instruction is presented to the datapath.
exec_ready  input  1  datapath accepts the instruction this cycle.
jmp_addr  input  ADDR_W  jump target from the datapath; sampled at JMP handshake.
zero_flag  input  1  datapath Z flag; used only with JZ_EN.
halted  output  1  PC left the program range; sticky until reset.
illegal_op  output  1  an undefined opcode was fetched; sticky until reset.
instr_count  output  CNT_W  count of retired instructions; saturating.

Behaviour:
- Reset (async, immediate, also mid-instruction): PC=0, state FETCH, opcode=0, operand=0, exec_valid=0, halted=0, illegal_op=0, instr_count=0.
- States: FETCH -> WAIT -> DECODE -> EXEC -> FETCH. HALT is terminal.
- FETCH: address=PC. program_memory samples it at the closing edge.
- WAIT: prog_data is valid. The unit captures opcode/operand at the closing edge.
- DECODE: opcode/operand outputs are stable and legality is checked.
  - Legal: 0001 ADD, 0010 SUB, 0011 AND, 0110 CMP, 1001 JMP, 1011 IN, 1101 STA, 1110 OUT, 1111 LDI.
  - Illegal: set illegal_op, skip EXEC, PC<=PC+1, go to FETCH (or HALT per the range rule).
- EXEC: exec_valid=1. Hold opcode/operand/exec_valid stable until exec_ready=1 (unbounded stall allowed).
  - On handshake: instr_count+1, saturating at all-ones.
  - JMP: PC<=jmp_addr. All other opcodes: PC<=PC+1.
- Minimum latency is 4 cycles per instruction. exec_valid deasserts the cycle after the handshake.
- Range rule: if the next PC >= PROG_LEN, go to HALT instead of FETCH. This applies to both sequential and jump targets.
- HALT: halted=1, exec_valid=0, address holds the last in-range PC, and the instr_count value is frozen. Only reset exits.
- opcode/operand keep their last value outside DECODE/EXEC.
- No address wrap: PC+1 is compared with PROG_LEN at ADDR_W+1 bits.

Optional Feature:
Macro JZ_EN.
- Defined: opcode 1010 (JZ) is legal. At the EXEC handshake, PC<=jmp_addr if zero_flag=1, else PC+1. The range rule still applies.
- Undefined: 1010 is illegal, zero_flag is ignored, and the port is still present.

Decomposition:
- Package proc_isa_pkg: 4-bit opcode localparams (OP_ADD..OP_LDI, OP_JZ), state enum type, OPC_W=4 and OPR_W=4 constants.
- One sub-module: isa_decoder, a combinational opcode -> {legal, is_jump, is_cond_jump} block, with the JZ_EN check inside it.

Test Plan:
- Reset release with memory holding LDI 0001 at address 0 -> address=0, then exec_valid high in the 4th cycle with opcode=1111, operand=0001; instr_count=1 after the handshake.
- Run 28 words with exec_ready tied high -> addresses 0..27 each held 4 cycles, then halted=1 after word 27, instr_count=28, exec_valid stays 0.
- Hold exec_ready low for 5 cycles in EXEC of STA 1101_0010 -> opcode/operand/exec_valid are stable throughout and the PC does not advance until ready.
- JMP word 1001_1111 at address 25 with jmp_addr=6 -> next address=6. A second run with jmp_addr=40 -> halted=1.
- Word 0100_0000 at address 3 -> illegal_op=1, no exec_valid for it, next address=4.
- Assert rst during EXEC of word 10 -> all outputs return to reset values immediately and the fetch restarts at 0. With JZ_EN: 1010_xxxx and zero_flag=1 jumps to jmp_addr; zero_flag=0 goes to PC+1.
